// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C slave with byte-wide rx/tx valid/ready handshakes.
// Define I2C_SLAVE_CLK_STRETCH_EN to stretch SCL instead of dropping/padding bytes.
`timescale 1ns/1ps
module i2c_slave_responder #(
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h22
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_o,
  output logic                      sda_o,
  output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  input  logic [I2C_DATA_WIDTH-1:0] tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic                      start_o,
  output logic                      stop_o,
  output logic                      rw_o,
  output logic                      busy_o,
  output logic                      overrun_o
);
  localparam int SW = (I2C_ADDR_WIDTH >= I2C_DATA_WIDTH) ? I2C_ADDR_WIDTH : I2C_DATA_WIDTH;
  localparam int CW = $clog2(SW + 2);
  localparam logic [CW-1:0] ABITS = CW'(I2C_ADDR_WIDTH);
  localparam logic [CW-1:0] DBITS = CW'(I2C_DATA_WIDTH);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  localparam logic STRETCH = 1'b1;
`else
  localparam logic STRETCH = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK} state_t;
  state_t r_state, w_nxt;
  logic [1:0] r_scl_s, r_sda_s;
  logic r_scl_d, r_sda_d;
  logic [SW-1:0] r_shift;
  logic [I2C_DATA_WIDTH-1:0] r_tx_sh, r_rx_data;
  logic [CW-1:0] r_cnt;
  logic r_phase, r_stretch, r_rw, r_busy, r_overrun, r_rx_valid, r_start, r_stop;
  logic w_scl, w_sda, w_rise, w_fall, w_start, w_stop;
  logic w_addr_last, w_match, w_wr_last, w_turn, w_hold, w_go, w_load;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_scl_s <= '1;
      r_sda_s <= '1;
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_s <= {r_scl_s[0], scl_i};
      r_sda_s <= {r_sda_s[0], sda_i};
      r_scl_d <= r_scl_s[1];
      r_sda_d <= r_sda_s[1];
    end
  assign w_scl   = r_scl_s[1];
  assign w_sda   = r_sda_s[1];
  assign w_rise  = w_scl && !r_scl_d;
  assign w_fall  = !w_scl && r_scl_d;
  assign w_start = w_scl && r_scl_d && r_sda_d && !w_sda;
  assign w_stop  = w_scl && r_scl_d && !r_sda_d && w_sda;
  assign w_addr_last = r_state == ADDR && w_rise && r_cnt == ABITS;
  assign w_match     = r_shift[I2C_ADDR_WIDTH-1:0] == SLAVE_ADDR;
  assign w_wr_last   = r_state == WR_DATA && w_rise && r_cnt == DBITS - CW'(1);
  // r_phase marks the second half of an acknowledge slot; the slot ends on the next SCL fall
  assign w_turn = (r_state == ADDR_ACK || r_state == WR_ACK || r_state == RD_ACK) && r_phase && (w_fall || r_stretch);
  assign w_hold = STRETCH && w_turn && (r_state == WR_ACK ? r_rx_valid : (r_state == RD_ACK || r_rw) && !tx_valid_i);
  assign w_go   = w_turn && !w_hold && !w_start && !w_stop;
  assign w_load = w_go && (r_state == RD_ACK || (r_state == ADDR_ACK && r_rw));
  assign scl_o      = !r_stretch;
  assign sda_o      = ((r_state == ADDR_ACK || r_state == WR_ACK) && r_phase) ? 1'b0 :
                      r_state == RD_DATA ? r_tx_sh[I2C_DATA_WIDTH-1] : 1'b1;
  assign tx_ready_o = w_load && tx_valid_i;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign start_o    = r_start;
  assign stop_o     = r_stop;
  assign rw_o       = r_rw;
  assign busy_o     = r_busy;
  assign overrun_o  = r_overrun;
  always_comb begin
    w_nxt = r_state;
    if (w_start) w_nxt = ADDR;
    else if (w_stop) w_nxt = IDLE;
    else
      unique case (r_state)
        ADDR:     if (w_addr_last) w_nxt = w_match ? ADDR_ACK : IDLE;
        ADDR_ACK: if (w_go) w_nxt = r_rw ? RD_DATA : WR_DATA;
        WR_DATA:  if (w_wr_last) w_nxt = WR_ACK;
        WR_ACK:   if (w_go) w_nxt = WR_DATA;
        RD_DATA:  if (w_fall && r_cnt == DBITS) w_nxt = RD_ACK;
        RD_ACK:   w_nxt = (w_rise && !r_phase && w_sda) ? IDLE : w_go ? RD_DATA : RD_ACK;
        default:  w_nxt = r_state;
      endcase
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_tx_sh    <= '0;
      r_rx_data  <= '0;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_stretch  <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_start <= w_start;
      r_stop  <= w_stop;
      r_busy  <= w_nxt == ADDR_ACK ? 1'b1 : w_nxt == IDLE ? 1'b0 : r_busy;
      if (r_rx_valid && rx_ready_i) r_rx_valid <= 1'b0;
      if (w_start || w_stop) begin
        r_cnt     <= '0;
        r_phase   <= 1'b0;
        r_stretch <= 1'b0;
      end else begin
        r_stretch <= w_hold;
        if (w_go) begin
          r_cnt   <= '0;
          r_phase <= 1'b0;
        end
        if (w_load) begin
          r_tx_sh <= tx_valid_i ? tx_data_i : '1;
          if (!tx_valid_i && !STRETCH) r_overrun <= 1'b1;
        end
        if ((r_state == ADDR || r_state == WR_DATA || r_state == RD_DATA) && w_rise) r_cnt <= r_cnt + CW'(1);
        if ((r_state == ADDR || r_state == WR_DATA) && w_rise) r_shift <= {r_shift[SW-2:0], w_sda};
        if (w_addr_last) r_rw <= w_sda;
        if ((r_state == ADDR_ACK || r_state == WR_ACK) && w_fall && !r_phase) r_phase <= 1'b1;
        if (r_state == RD_ACK && w_rise && !r_phase && !w_sda) r_phase <= 1'b1;
        if (r_state == RD_DATA && w_fall && r_cnt != DBITS) r_tx_sh <= r_tx_sh << 1;
        if (w_wr_last) begin
          if (r_rx_valid && !rx_ready_i) begin
            if (!STRETCH) r_overrun <= 1'b1;
          end else begin
            r_rx_data  <= {r_shift[I2C_DATA_WIDTH-2:0], w_sda};
            r_rx_valid <= 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: bit-banged I2C master against the responder, with rx/tx scoreboards.
`timescale 1ns/1ps
module tb_i2c_slave_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1, m_sda = 1'b1;
  logic scl_i, sda_i, scl_o, sda_o;
  logic [7:0] rx_data_o, tx_data_i = 8'h00;
  logic rx_valid_o, rx_ready_i = 1'b1, tx_valid_i = 1'b1, tx_ready_o;
  logic start_o, stop_o, rw_o, busy_o, overrun_o;
  int n_chk = 0, n_fail = 0;
  int n_start = 0, n_stop = 0, n_pop = 0, n_rx = 0;
  bit busy_seen = 0, scl_low_seen = 0;
  logic [7:0] exp_rx[$], exp_rd[$];
  assign scl_i = m_scl & scl_o;
  assign sda_i = m_sda & sda_o;
  always #5 clk = ~clk;
  i2c_slave_responder dut (
    .clk_i(clk), .rst_i(rst_n), .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .start_o(start_o), .stop_o(stop_o), .rw_o(rw_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (start_o) n_start++;
    if (stop_o) n_stop++;
    if (busy_o) busy_seen = 1;
    if (!scl_o) scl_low_seen = 1;
    if (rx_valid_o && rx_ready_i) begin
      n_rx++;
      if (exp_rx.size() == 0) check("rx_queue_size", exp_rx.size(), 1);
      else check("rx_data", rx_data_o, exp_rx.pop_front());
    end
    if (tx_ready_o && tx_valid_i) begin
      n_pop++;
      exp_rd.push_back(tx_data_i);
      @(posedge clk);
      #1 tx_data_i = tx_data_i + 8'd1;
    end
  end
  initial begin
    #900_000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end
  task automatic q();
    repeat (8) @(negedge clk);
  endtask
  task automatic scl_high();
    m_scl = 1'b1;
    for (int i = 0; i < 4000 && scl_i !== 1'b1; i++) @(negedge clk);
    if (scl_i !== 1'b1) check("scl_release_timeout", scl_i, 1);
  endtask
  task automatic write_bit(input logic v);
    m_sda = v; q(); scl_high(); q(); q(); m_scl = 1'b0; q();
  endtask
  task automatic read_bit(output logic r);
    m_sda = 1'b1; q(); scl_high(); q(); r = sda_i; q(); m_scl = 1'b0; q();
  endtask
  task automatic i2c_start();
    m_sda = 1'b1; q(); scl_high(); q(); m_sda = 1'b0; q(); m_scl = 1'b0; q();
  endtask
  task automatic i2c_stop();
    m_sda = 1'b0; q(); scl_high(); q(); m_sda = 1'b1; q();
  endtask
  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask
  task automatic read_byte(output logic [7:0] b, input logic nack);
    logic r;
    for (int i = 0; i < 8; i++) begin
      read_bit(r);
      b = {b[6:0], r};
    end
    write_bit(nack);
  endtask
  task automatic check_rd(input string tag, input logic [7:0] b);
    if (exp_rd.size() == 0) check(tag, exp_rd.size(), 1);
    else check(tag, b, exp_rd.pop_front());
  endtask
  initial begin
    logic ack;
    logic [7:0] b;
    int s0, s1, s2;
    repeat (3) @(negedge clk);
    check("rst_sda_o", sda_o, 1);
    check("rst_scl_o", scl_o, 1);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_flags", {rx_valid_o, tx_ready_o, start_o, stop_o, rw_o, busy_o, overrun_o}, 0);
    rst_n = 1'b1;
    q();
    // long write: address 0x22 write, bytes 0..31
    s0 = n_stop;
    i2c_start();
    write_byte(8'h44, ack);
    check("wr_addr_ack", ack, 0);
    check("wr_busy", busy_o, 1);
    for (int i = 0; i < 32; i++) begin
      exp_rx.push_back(8'(i));
      write_byte(8'(i), ack);
      check("wr_byte_ack", ack, 0);
    end
    i2c_stop();
    q();
    check("wr_stop_pulses", n_stop - s0, 1);
    check("wr_rx_count", n_rx, 32);
    check("wr_rx_left", exp_rx.size(), 0);
    check("wr_busy_after_stop", busy_o, 0);
    // long read: bytes 100..131, NACK on the last
    tx_data_i = 8'd100;
    exp_rd.delete();
    s0 = n_pop;
    i2c_start();
    write_byte(8'h45, ack);
    check("rd_addr_ack", ack, 0);
    check("rd_rw", rw_o, 1);
    for (int i = 0; i < 32; i++) begin
      read_byte(b, i == 31);
      check_rd("rd_byte", b);
    end
    q();
    check("rd_pops", n_pop - s0, 32);
    check("rd_idle_after_nack", busy_o, 0);
    i2c_stop();
    q();
    // wrong address 0x23
    s0 = n_rx; s1 = n_pop; busy_seen = 0;
    i2c_start();
    write_byte(8'h46, ack);
    check("bad_addr_nack", ack, 1);
    i2c_stop();
    q();
    check("bad_addr_no_rx", n_rx - s0, 0);
    check("bad_addr_no_tx", n_pop - s1, 0);
    check("bad_addr_busy", busy_seen, 0);
    // write, repeated start, read one byte
    tx_data_i = 8'h3F;
    exp_rd.delete();
    s0 = n_start; s1 = n_stop;
    i2c_start();
    write_byte(8'h44, ack);
    check("rs_wr_ack", ack, 0);
    check("rs_rw_write", rw_o, 0);
    exp_rx.push_back(8'h40);
    write_byte(8'h40, ack);
    check("rs_data_ack", ack, 0);
    i2c_start();
    check("rs_no_stop", n_stop - s1, 0);
    write_byte(8'h45, ack);
    check("rs_rd_ack", ack, 0);
    check("rs_rw_read", rw_o, 1);
    read_byte(b, 1'b1);
    check_rd("rs_rd_byte", b);
    check("rs_rd_value", b, 8'h3F);
    i2c_stop();
    q();
    check("rs_start_pulses", n_start - s0, 2);
    check("rs_stop_pulses", n_stop - s1, 1);
    // receiver stalled across two write bytes
    check("ov_clear_before", overrun_o, 0);
    rx_ready_i = 1'b0;
    i2c_start();
    write_byte(8'h44, ack);
    exp_rx.push_back(8'hA5);
    scl_low_seen = 0;
    write_byte(8'hA5, ack);
    check("ov_first_ack", ack, 0);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    exp_rx.push_back(8'h5A);
    fork
      begin
        repeat (300) @(negedge clk);
        check("st_scl_stretched", scl_low_seen, 1);
        rx_ready_i = 1'b1;
      end
    join_none
    write_byte(8'h5A, ack);
    check("st_second_ack", ack, 0);
    q();
    check("st_no_overrun", overrun_o, 0);
`else
    write_byte(8'h5A, ack);
    check("ov_second_ack", ack, 0);
    check("ov_flag", overrun_o, 1);
    check("ov_kept_first", rx_data_o, 8'hA5);
    check("ov_still_valid", rx_valid_o, 1);
    check("ov_never_stretched", scl_low_seen, 0);
    rx_ready_i = 1'b1;
    q();
`endif
    check("ov_rx_left", exp_rx.size(), 0);
    i2c_stop();
    q();
    // reset in the middle of a read byte
    tx_data_i = 8'h3F;
    i2c_start();
    write_byte(8'h45, ack);
    check("rst_rd_ack", ack, 0);
    check("rst_sda_driven", sda_o, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_sda", sda_o, 1);
    check("rst_mid_scl", scl_o, 1);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_overrun", overrun_o, 0);
    exp_rd.delete();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    q();
    s0 = n_start; s1 = n_stop; s2 = n_rx;
    i2c_start();
    write_byte(8'h44, ack);
    check("post_rst_addr_ack", ack, 0);
    exp_rx.push_back(8'h5C);
    write_byte(8'h5C, ack);
    check("post_rst_data_ack", ack, 0);
    i2c_stop();
    q();
    check("post_rst_start", n_start - s0, 1);
    check("post_rst_stop", n_stop - s1, 1);
    check("post_rst_rx", n_rx - s2, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
